// File: rtl/store_buffer_pkg.sv
// Store buffer shared types and sizes.
// Optional STORE_BUFFER_UNRESOLVED_FLAG_EN adds a bypass replay flag.
package store_buffer_pkg;

  localparam int SB_ENTRY    = 8;
  localparam int WORD_SIZE_P = 16;
  localparam int SB_IDX_W    = $clog2(SB_ENTRY);

  typedef struct packed {
    logic [SB_IDX_W-1:0]    sb_dest;
    logic [WORD_SIZE_P-1:0] address;
    logic [WORD_SIZE_P-1:0] result;
  } CDB_sb_t;

  localparam int CDB_SB_WIDTH = $bits(CDB_sb_t);

  typedef struct packed {
    logic                   valid;
    logic                   resolved;
    logic                   committed;
    logic [WORD_SIZE_P-1:0] addr;
    logic [WORD_SIZE_P-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Memory write port of the store buffer.
// Valid/ready handshake; master side is the store buffer.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic                   mem_w_v;
  logic [WORD_SIZE_P-1:0] mem_w_addr;
  logic [WORD_SIZE_P-1:0] mem_w_data;
  logic                   mem_w_ready;

  modport master (
    output mem_w_v,
    output mem_w_addr,
    output mem_w_data,
    input  mem_w_ready
  );

  modport slave (
    input  mem_w_v,
    input  mem_w_addr,
    input  mem_w_data,
    output mem_w_ready
  );

endinterface

// File: rtl/sb_bypass_match.sv
// Youngest-older-store match for load forwarding.
// STORE_BUFFER_UNRESOLVED_FLAG_EN adds the unresolved-older output.
module sb_bypass_match
  import store_buffer_pkg::*;
(
  input  sb_entry_t              ent_i [SB_ENTRY],
  input  logic [SB_IDX_W-1:0]    head_i,
  input  logic [SB_IDX_W-1:0]    sb_num_i,
  input  logic [WORD_SIZE_P-1:0] addr_i,
`ifdef STORE_BUFFER_UNRESOLVED_FLAG_EN
  output logic                   unres_o,
`endif
  output logic                   hit_o,
  output logic [WORD_SIZE_P-1:0] value_o
);

  logic [SB_IDX_W-1:0] cnt;
  logic [SB_IDX_W-1:0] idx;

  // walk oldest to youngest; later matches override
  always_comb begin
    cnt     = sb_num_i - head_i;
    idx     = '0;
    hit_o   = 1'b0;
    value_o = '0;
`ifdef STORE_BUFFER_UNRESOLVED_FLAG_EN
    unres_o = 1'b0;
`endif
    for (int k = 0; k < SB_ENTRY; k++) begin
      idx = head_i + SB_IDX_W'(k);
      if (SB_IDX_W'(k) < cnt) begin
        if (ent_i[idx].valid &&
            ent_i[idx].resolved &&
            ent_i[idx].addr == addr_i) begin
          hit_o   = 1'b1;
          value_o = ent_i[idx].data;
        end
`ifdef STORE_BUFFER_UNRESOLVED_FLAG_EN
        if (ent_i[idx].valid &&
            !ent_i[idx].resolved) begin
          unres_o = 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order circular store buffer: alloc, writeback, commit, drain.
// STORE_BUFFER_UNRESOLVED_FLAG_EN adds sb_ld_bypass_unresolved_o.
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   alloc_v_i,
  output logic [SB_IDX_W-1:0]    alloc_idx_o,
  output logic                   full_o,
  output logic                   empty_o,
  input  logic                   lsu_sb_v_i,
  input  CDB_sb_t                lsu_sb_i,
  input  logic [WORD_SIZE_P-1:0] exe_ld_bypass_addr_i,
  input  logic [SB_IDX_W-1:0]    exe_ld_bypass_sb_num_i,
  output logic                   sb_ld_bypass_valid_o,
  output logic [WORD_SIZE_P-1:0] sb_ld_bypass_value_o,
`ifdef STORE_BUFFER_UNRESOLVED_FLAG_EN
  output logic                   sb_ld_bypass_unresolved_o,
`endif
  input  logic                   commit_st_v_i,
  input  logic                   mispredict_i,
  store_buffer_if.master         mem_w
);

  sb_entry_t           ent_q [SB_ENTRY];
  sb_entry_t           ent_d [SB_ENTRY];
  logic [SB_IDX_W-1:0] head_q, head_d;
  logic [SB_IDX_W-1:0] cmt_q, cmt_d;
  logic [SB_IDX_W-1:0] tail_q, tail_d;
  logic [SB_ENTRY-1:0] vld;
  logic                alloc_ok;
  logic                wb_ok;
  logic                drain;

  // occupancy flags from registered valid bits
  always_comb begin
    vld = '0;
    for (int i = 0; i < SB_ENTRY; i++) begin
      vld[i] = ent_q[i].valid;
    end
  end

  assign full_o      = &vld;
  assign empty_o     = ~|vld;
  assign alloc_idx_o = tail_q;

  assign mem_w.mem_w_v    = ent_q[head_q].valid &
                            ent_q[head_q].resolved &
                            ent_q[head_q].committed;
  assign mem_w.mem_w_addr = ent_q[head_q].addr;
  assign mem_w.mem_w_data = ent_q[head_q].data;

  assign alloc_ok = alloc_v_i & ~full_o & ~mispredict_i;
  assign wb_ok    = lsu_sb_v_i & ent_q[lsu_sb_i.sb_dest].valid;
  assign drain    = mem_w.mem_w_v & mem_w.mem_w_ready;

  // next entry state; commit lands before the flush
  always_comb begin
    ent_d = ent_q;
    if (wb_ok) begin
      ent_d[lsu_sb_i.sb_dest].addr     = lsu_sb_i.address;
      ent_d[lsu_sb_i.sb_dest].data     = lsu_sb_i.result;
      ent_d[lsu_sb_i.sb_dest].resolved = 1'b1;
    end
    if (commit_st_v_i) begin
      ent_d[cmt_q].committed = 1'b1;
    end
    if (alloc_ok) begin
      ent_d[tail_q].valid     = 1'b1;
      ent_d[tail_q].resolved  = 1'b0;
      ent_d[tail_q].committed = 1'b0;
    end
    if (drain) begin
      ent_d[head_q].valid = 1'b0;
    end
    if (mispredict_i) begin
      for (int i = 0; i < SB_ENTRY; i++) begin
        if (!ent_d[i].committed) begin
          ent_d[i].valid = 1'b0;
        end
      end
    end
  end

  // pointer advance; flush rewinds tail to commit point
  always_comb begin
    head_d = head_q + SB_IDX_W'(drain);
    cmt_d  = cmt_q + SB_IDX_W'(commit_st_v_i);
    tail_d = tail_q + SB_IDX_W'(alloc_ok);
    if (mispredict_i) begin
      tail_d = cmt_d;
    end
  end

  // state registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < SB_ENTRY; i++) begin
        ent_q[i] <= '0;
      end
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      ent_q  <= ent_d;
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
    end
  end

  // commit must target a pending store
  always_ff @(posedge clk_i) begin
    if (reset_n_i && commit_st_v_i) begin
      assert (ent_q[cmt_q].valid &&
              !ent_q[cmt_q].committed)
        else $error("store_buffer: commit with no pending store");
    end
  end

  sb_bypass_match u_match (
    .ent_i    (ent_q),
    .head_i   (head_q),
    .sb_num_i (exe_ld_bypass_sb_num_i),
    .addr_i   (exe_ld_bypass_addr_i),
`ifdef STORE_BUFFER_UNRESOLVED_FLAG_EN
    .unres_o  (sb_ld_bypass_unresolved_o),
`endif
    .hit_o    (sb_ld_bypass_valid_o),
    .value_o  (sb_ld_bypass_value_o)
  );

endmodule
